camera_pixel_assembler: RTL

- Sits directly upstream of the camera statistics/display blocks, between the raw camera byte capture and everything that consumes pixels.
- Takes the byte stream with its hsync (HREF) and vsync markers and assembles RGB565 pixels, two bytes per pixel.
- Produces pixel coordinates plus the hcount/vcount/hsync/vsync/valid_byte signals, aligned so that the hcount/vcount, row-length and frame-length display stages can capture correct values on sync falling edges.

---
 rtl/camera_pkg.sv | 21 ++
 rtl/sync_edge_detect.sv | 24 ++
 rtl/camera_pixel_assembler.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/camera_pkg.sv
// Shared types and default widths for the camera pixel assembly path.
package camera_pkg;

  localparam int DEFAULT_HCOUNT_W    = 13;
  localparam int DEFAULT_VCOUNT_W    = 12;
  localparam int DEFAULT_FRAME_CNT_W = 16;

  typedef enum logic [1:0] {
    FRAME_WAIT = 2'd0,
    LINE_IDLE  = 2'd1,
    BYTE_HI    = 2'd2,
    BYTE_LO    = 2'd3
  } state_t;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

endpackage

// File: rtl/sync_edge_detect.sv
// Registers one sync marker on accepted bytes; rise/fall compare the current byte
// against the previous accepted byte. 1-cycle register, no backpressure.
module sync_edge_detect (
  input  logic clk_in,
  input  logic rst_in,
  input  logic valid_byte_in,
  input  logic sync_in,
  output logic prev,
  output logic rise,
  output logic fall
);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      prev <= 1'b0;
    end else if (valid_byte_in) begin
      prev <= sync_in;
    end
  end

  assign rise = valid_byte_in && sync_in && !prev;
  assign fall = valid_byte_in && !sync_in && prev;

endmodule

// File: rtl/camera_pixel_assembler.sv
// Pairs camera bytes into RGB565 pixels with line/frame counters; all outputs one
// cycle after the accepting byte strobe. No backpressure: every valid byte is consumed.
module camera_pixel_assembler
  import camera_pkg::*;
#(
  parameter int HCOUNT_W    = DEFAULT_HCOUNT_W,
  parameter int VCOUNT_W    = DEFAULT_VCOUNT_W,
  parameter int FRAME_CNT_W = DEFAULT_FRAME_CNT_W
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   valid_byte_in,
  input  logic [7:0]             data_byte_in,
  input  logic                   hsync_in,
  input  logic                   vsync_in,
  output logic                   pixel_valid_out,
  output logic [15:0]            pixel_data_out,
  output logic [HCOUNT_W-1:0]    pixel_x_out,
  output logic [VCOUNT_W-1:0]    pixel_y_out,
  output logic [HCOUNT_W-1:0]    hcount_out,
  output logic [VCOUNT_W-1:0]    vcount_out,
  output logic                   hsync_out,
  output logic                   vsync_out,
  output logic                   valid_byte_out,
  output logic [FRAME_CNT_W-1:0] frame_count_out,
  output logic                   odd_line_err_out
);

  logic hrise, hfall, vrise, vfall;

  sync_edge_detect u_hsync_edge (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .valid_byte_in (valid_byte_in),
    .sync_in       (hsync_in),
    .prev          (hsync_out),
    .rise          (hrise),
    .fall          (hfall)
  );

  sync_edge_detect u_vsync_edge (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .valid_byte_in (valid_byte_in),
    .sync_in       (vsync_in),
    .prev          (vsync_out),
    .rise          (vrise),
    .fall          (vfall)
  );

  state_t                 state, state_nxt;
  logic [7:0]             hi_byte, hi_byte_nxt;
  logic [HCOUNT_W-1:0]    hcount_nxt;
  logic [VCOUNT_W-1:0]    vcount_nxt;
  logic [FRAME_CNT_W-1:0] frame_nxt;
  logic                   err_nxt;
  logic                   vclr_pend, vclr_nxt;
  logic                   emit;
  rgb565_t                pix;

  logic [HCOUNT_W-1:0] hcount_inc;
  logic [VCOUNT_W-1:0] vcount_inc;

  assign hcount_inc     = (hcount_out == '1) ? hcount_out : hcount_out + HCOUNT_W'(1);
  assign vcount_inc     = (vcount_out == '1) ? vcount_out : vcount_out + VCOUNT_W'(1);
  assign pixel_data_out = pix;

  always_comb begin
    state_nxt   = state;
    hi_byte_nxt = hi_byte;
    hcount_nxt  = hcount_out;
    vcount_nxt  = vcount_out;
    frame_nxt   = frame_count_out;
    err_nxt     = odd_line_err_out;
    vclr_nxt    = vclr_pend;
    emit        = 1'b0;
    if (valid_byte_in) begin
      if (state == FRAME_WAIT) begin
        if (vfall) begin
          state_nxt = LINE_IDLE;
          frame_nxt = frame_count_out + FRAME_CNT_W'(1);
          vclr_nxt  = 1'b1;
        end
      end else begin
        if (hfall) begin
          vcount_nxt = vcount_inc;
          state_nxt  = LINE_IDLE;
        end else if (hsync_in && !vsync_in) begin
          case (state)
            LINE_IDLE: begin
              hi_byte_nxt = data_byte_in;
              state_nxt   = BYTE_LO;
              if (hrise) begin
                hcount_nxt = '0;
                if (vclr_pend) begin
                  vcount_nxt = '0;
                  vclr_nxt   = 1'b0;
                end
              end
            end
            BYTE_LO: begin
              emit       = 1'b1;
              hcount_nxt = hcount_inc;
              state_nxt  = BYTE_HI;
            end
            default: begin
              hi_byte_nxt = data_byte_in;
              state_nxt   = BYTE_LO;
            end
          endcase
        end
        // A line or frame ending while a high byte is held leaves it unpaired.
        if (state == BYTE_LO && (hfall || vrise)) begin
          err_nxt     = 1'b1;
          hi_byte_nxt = '0;
        end
        if (vrise) begin
          state_nxt = FRAME_WAIT;
        end
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state            <= FRAME_WAIT;
      hi_byte          <= '0;
      vclr_pend        <= 1'b0;
      hcount_out       <= '0;
      vcount_out       <= '0;
      frame_count_out  <= '0;
      odd_line_err_out <= 1'b0;
      pixel_valid_out  <= 1'b0;
      valid_byte_out   <= 1'b0;
      pix              <= '0;
      pixel_x_out      <= '0;
      pixel_y_out      <= '0;
    end else begin
      state            <= state_nxt;
      hi_byte          <= hi_byte_nxt;
      vclr_pend        <= vclr_nxt;
      hcount_out       <= hcount_nxt;
      vcount_out       <= vcount_nxt;
      frame_count_out  <= frame_nxt;
      odd_line_err_out <= err_nxt;
      pixel_valid_out  <= emit;
      valid_byte_out   <= valid_byte_in;
      if (emit) begin
        pix         <= rgb565_t'({hi_byte, data_byte_in});
        pixel_x_out <= hcount_out;
        pixel_y_out <= vcount_out;
      end
    end
  end

endmodule
